// File: rtl/sync_fifo_wr_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding,
// legacy delay constant and the width helper used to size index/counter fields.
package sync_fifo_wr_arb_pkg;

  // Delay constant kept for compatibility with older flop models in the codebase.
  localparam int DLY = 1;

  // Arbiter states: IDLE arbitrates, BURST streams words from the current owner.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Number of bits needed to hold the unsigned value 'value' (never less than 1).
  function automatic int get_width(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((value >> i) != 0) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// searching upward from rr_ptr with wrap-around. rr_ptr has highest priority.
// Kept generic so read-side schedulers can reuse it.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         valid,
  output logic [W-1:0] winner
);

  // Scan all N positions starting at rr_ptr; the first hit wins.
  always_comb begin
    int           idx;
    logic [W-1:0] cand;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = W'(idx);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin, burst-aware write arbiter sharing one sync_fifo write port
// among N_REQ producers. An owner keeps the port for up to MAX_BURST accepted
// words or until it drops its request; a one-cycle IDLE gap separates owners.
module sync_fifo_wr_arb
  import sync_fifo_wr_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  localparam int OWN_W    = get_width(N_REQ - 1),
  localparam int CNT_W    = get_width(MAX_BURST)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    fifo_wreq,
  output logic [DATA_W-1:0]       fifo_wdata,
  input  logic                    fifo_full,
  output logic [OWN_W-1:0]        owner,
  output logic                    busy
);

  arb_state_e         state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic               pick_valid;
  logic [OWN_W-1:0]   pick_winner;
  logic [DATA_W-1:0]  slices [N_REQ];
  logic               accept;
  logic               burst_exit;

  rr_pick #(
    .N (N_REQ),
    .W (OWN_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Unpack the flattened producer bus so the owner's word can be indexed directly.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      slices[i] = wdata[i*DATA_W +: DATA_W];
    end
  end

  // The owner's slice is presented to the FIFO whether or not it is granted.
  always_comb begin
    fifo_wdata = slices[owner_q];
  end

  // Next-state, grant and write-strobe logic for the IDLE/BURST controller.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    fifo_wreq   = 1'b0;
    accept      = 1'b0;
    burst_exit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d     = pick_winner;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end

      BURST: begin
        accept       = req[owner_q] & ~fifo_full;
        gnt[owner_q] = accept;
        fifo_wreq    = accept;

        if (!req[owner_q]) begin
          burst_exit = 1'b1;
        end else if (accept) begin
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            burst_exit = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end

        if (burst_exit) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
          rr_ptr_d    = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + OWN_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops the FSM to IDLE so gnt/fifo_wreq fall at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == BURST);

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Directed bench for sync_fifo_wr_arb. Two instances share the producer bus:
// dut_a uses MAX_BURST=4, dut_b uses MAX_BURST=1. Expected FIFO words are
// pushed to a scoreboard as grants are planned and popped on each FIFO write.
module tb_sync_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic            fifo_full;

  logic [N-1:0]    gnt_a, gnt_b;
  logic            wreq_a, wreq_b;
  logic [DW-1:0]   fdata_a, fdata_b;
  logic [1:0]      owner_a, owner_b;
  logic            busy_a, busy_b;

  int              n_assert = 0;
  int              n_fail   = 0;
  logic [31:0]     sb [$];
  int              prod_idx [N];
  int              exp_idx  [N];
  logic            use_b = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt_a),
    .fifo_wreq  (wreq_a),
    .fifo_wdata (fdata_a),
    .fifo_full  (fifo_full),
    .owner      (owner_a),
    .busy       (busy_a)
  );

  sync_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt_b),
    .fifo_wreq  (wreq_b),
    .fifo_wdata (fdata_b),
    .fifo_full  (fifo_full),
    .owner      (owner_b),
    .busy       (busy_b)
  );

  // Producer word: id in the top byte, per-producer sequence number below.
  function automatic logic [31:0] word_of(input int p, input int idx);
    return (p << 24) | (idx & 32'h00FF_FFFF);
  endfunction

  task automatic refresh_wdata();
    for (int i = 0; i < N; i++) begin
      wdata[i*DW +: DW] = word_of(i, prod_idx[i]);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the selected instance's outputs against the planned cycle.
  task automatic checkOutput(input logic [N-1:0] exp_gnt, input logic exp_busy,
                             input int exp_owner);
    logic [N-1:0]  g;
    logic          wr;
    logic          bz;
    logic [1:0]    own;
    logic [DW-1:0] fd;
    logic [31:0]   want;
    g   = use_b ? gnt_b   : gnt_a;
    wr  = use_b ? wreq_b  : wreq_a;
    bz  = use_b ? busy_b  : busy_a;
    own = use_b ? owner_b : owner_a;
    fd  = use_b ? fdata_b : fdata_a;
    check("gnt", 32'(g), 32'(exp_gnt));
    check("fifo_wreq", 32'(wr), 32'(|exp_gnt));
    check("busy", 32'(bz), 32'(exp_busy));
    if (exp_owner >= 0) check("owner", 32'(own), exp_owner);
    check("gnt_onehot0", 32'($onehot0(g)), 32'd1);
    check("write_while_full", 32'(wr & fifo_full), 32'd0);
    if (wr) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 32'(sb.size()), 32'd1);
      end else begin
        want = sb.pop_front();
        check("fifo_wdata", fd, want);
      end
    end
  endtask

  // One clock cycle: plan expected words, check, advance producers that were granted.
  task automatic applyStimulus(input logic [N-1:0] exp_gnt, input logic exp_busy,
                               input int exp_owner);
    logic [N-1:0] g_seen;
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        sb.push_back(word_of(i, exp_idx[i]));
        exp_idx[i]++;
      end
    end
    #1;
    checkOutput(exp_gnt, exp_busy, exp_owner);
    g_seen = use_b ? gnt_b : gnt_a;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (g_seen[i]) prod_idx[i]++;
    end
    refresh_wdata();
    #1;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_gnt"},       32'(gnt_a),              32'd0);
    check({tag, "_fifo_wreq"}, 32'(wreq_a),             32'd0);
    check({tag, "_busy"},      32'(busy_a),             32'd0);
    check({tag, "_owner"},     32'(owner_a),            32'd0);
    check({tag, "_rr_ptr"},    32'(dut_a.rr_ptr_q),     32'd0);
    check({tag, "_burst_cnt"}, 32'(dut_a.burst_cnt_q),  32'd0);
  endtask

  task automatic doReset();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    #1;
    checkReset("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      prod_idx[i] = 0;
      exp_idx[i]  = 0;
    end
    refresh_wdata();
    rst_n     = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    #2;

    $display("[TB] single requester, bursts of 4");
    doReset();
    req = 4'b0001;
    applyStimulus(4'b0000, 1'b0, 0);
    repeat (4) applyStimulus(4'b0001, 1'b1, 0);
    check("rr_ptr_after_burst", 32'(dut_a.rr_ptr_q), 32'd1);
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (4) applyStimulus(4'b0001, 1'b1, 0);
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);

    $display("[TB] all requesters, round-robin rotation");
    doReset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      applyStimulus(4'b0000, 1'b0, -1);
      repeat (4) applyStimulus(4'(1 << (o % 4)), 1'b1, o % 4);
    end
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);

    $display("[TB] owner 2 stalled by fifo_full");
    doReset();
    req = 4'b0100;
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (2) applyStimulus(4'b0100, 1'b1, 2);
    fifo_full = 1'b1;
    repeat (3) begin
      applyStimulus(4'b0000, 1'b1, 2);
      check("burst_cnt_frozen", 32'(dut_a.burst_cnt_q), 32'd2);
    end
    fifo_full = 1'b0;
    repeat (2) applyStimulus(4'b0100, 1'b1, 2);
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);
    check("rr_ptr_after_full_burst", 32'(dut_a.rr_ptr_q), 32'd3);

    $display("[TB] owner 1 drops request with owner 3 pending");
    doReset();
    req = 4'b1010;
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (2) applyStimulus(4'b0010, 1'b1, 1);
    req = 4'b1000;
    applyStimulus(4'b0000, 1'b1, 1);
    check("rr_ptr_after_drop", 32'(dut_a.rr_ptr_q), 32'd2);
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (4) applyStimulus(4'b1000, 1'b1, 3);
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);

    $display("[TB] MAX_BURST=1 alternating producers 0 and 2");
    doReset();
    use_b = 1'b1;
    req   = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 1'b0, -1);
      applyStimulus((k % 2 == 0) ? 4'b0001 : 4'b0100, 1'b1, (k % 2 == 0) ? 0 : 2);
    end
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);
    use_b = 1'b0;

    $display("[TB] asynchronous reset in the middle of a burst");
    doReset();
    req = 4'b1000;
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (2) applyStimulus(4'b1000, 1'b1, 3);
    check("burst_cnt_before_reset", 32'(dut_a.burst_cnt_q), 32'd2);
    rst_n = 1'b0;
    #1;
    checkReset("midburst_reset");
    #1;
    rst_n = 1'b1;
    req   = 4'b1001;
    applyStimulus(4'b0000, 1'b0, -1);
    repeat (4) applyStimulus(4'b0001, 1'b1, 0);
    req = 4'b0000;
    applyStimulus(4'b0000, 1'b0, -1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wr_arb.md
Name: sync_fifo_wr_arb

Overview:
Round-robin, burst-aware write arbiter that shares one sync_fifo write port among N_REQ producers.
- A producer owns the FIFO for a burst of up to MAX_BURST words, or until it drops its request.
- Ownership then rotates to the next requester in round-robin order.
- Sits directly in front of sync_fifo. Drives its wreq/wdata and obeys its full_flg.

Parameters:
N_REQ, 4, number of producers (2..16)
DATA_W, 32, data width; must match the downstream FIFO
MAX_BURST, 8, maximum words accepted per ownership (1..256)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req  in  N_REQ  per-producer write request; bit i held high while producer i has data
wdata  in  N_REQ*DATA_W  flattened producer data; slice i = wdata[i*DATA_W +: DATA_W]
gnt  out  N_REQ  one-hot accept strobe; gnt[i]=1 means slice i is written this cycle
fifo_wreq  out  1  write strobe to FIFO
fifo_wdata  out  DATA_W  data to FIFO
fifo_full  in  1  FIFO full flag
owner  out  OWN_W  index of current owner; OWN_W = get_width(N_REQ-1)
busy  out  1  high in BURST state

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, gnt=0, fifo_wreq=0, busy=0.
- Registered state: state, owner, rr_ptr, burst_cnt (width get_width(MAX_BURST)).
- gnt, fifo_wreq and fifo_wdata are combinational from registered state plus req and fifo_full.

IDLE:
- gnt=0.
- If any req bit is set, pick the first set bit searching from rr_ptr upward with wrap (rr_ptr has highest priority).
- Register the winner into owner, clear burst_cnt, go to BURST.
- Arbitration costs exactly one cycle. The first grant appears the cycle after IDLE sees the request.

BURST:
- gnt[owner] = req[owner] & ~fifo_full; all other gnt bits are 0.
- fifo_wreq = |gnt.
- fifo_wdata = wdata slice of owner, driven regardless of gnt.
- Each accepted word increments burst_cnt.

Exit from BURST to IDLE (same edge):
- Condition (a): an accepted word makes burst_cnt reach MAX_BURST, or
- Condition (b): req[owner]=0.
- On exit: rr_ptr <= owner+1, wrapping N_REQ-1 -> 0; burst_cnt <= 0.
- Mandatory one-cycle IDLE gap between owners, even when other requests are pending.

fifo_full handling:
- Owner stalls in BURST; no grant; burst_cnt frozen.
- No timeout; the owner keeps ownership through full.
- If req[owner] drops while full, exit per (b).

Other boundaries:
- A requester that drops req mid-burst loses the remainder; no word is lost, because accept is gnt only.
- A producer must hold req and data stable until granted.
- A request arriving in a non-owner's bit during BURST waits. It is seen at the next IDLE.
- MAX_BURST=1: every word is followed by an IDLE cycle (50% max throughput). This is intended.
- Never more than one gnt bit high (one-hot-or-zero invariant).
- No write ever issued while fifo_full=1.
- Async reset mid-burst: all state returns to reset values immediately; gnt and fifo_wreq drop in the same cycle.
- Indices above N_REQ-1 are never produced.

Decomposition:
- Shared package/include: get_width() function (existing get_width.inc); localparams IDLE/BURST state encoding and DLY.
- One sub-module, rr_pick #(N): combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, winner index.
  - Reusable by future read-side schedulers.

Test Plan:
- N_REQ=4, MAX_BURST=4; req=4'b0001 held for 10 cycles, FIFO never full -> IDLE 1 cycle, gnt[0] 4 cycles, IDLE 1 cycle, gnt[0] 4 cycles; rr_ptr=1 after first burst.
- req=4'b1111 held -> owners 0,1,2,3,0 in order; each gets exactly 4 grants separated by single IDLE cycles; never two gnt bits set.
- Owner 2 granted; fifo_full=1 for 3 cycles after its 2nd word -> gnt=0 and fifo_wreq=0 for 3 cycles, burst_cnt holds 2, 2 more words after full drops, then exit.
- Owner 1 drops req after 2 words with req[3] pending -> exit to IDLE next edge; rr_ptr=2; owner 3 granted two cycles after the drop.
- MAX_BURST=1, req=4'b0101 -> alternating grants 0,2,0,2 with an IDLE cycle between each; fifo_wdata equals the owner's slice on every write.
- Assert rst_n low mid-burst (owner=3, burst_cnt=2) -> gnt, fifo_wreq and busy go 0 immediately; after release the first arbitration starts from rr_ptr=0.
